id_ex_hazard_stage: RTL

//  ID/EX pipeline register plus load-use hazard detection for the 5-stage MIPS core.

---
 rtl/id_ex_hazard_stage.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_hazard_stage.sv
// rtl/id_ex_hazard_stage.sv - ID/EX pipeline register with load-use hazard detection
//
// Purpose: holds the decoded instruction between ID and EX, inserts a one-cycle
// bubble on a load-use hazard, squashes the ID instruction on a taken branch and
// freezes on an external stall. Two saturating counters record inserted
// load-use bubbles and flush cycles.
//
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   *_ID_i                decoded instruction fields from ID (valid, ctrl, data, addrs)
//   flush_i               taken branch, squash the ID instruction
//   ext_stall_i           downstream busy, freeze this stage
//   *_IDEX_o              registered fields presented to EX / forwarding unit
//   PC_write_o            PC update enable
//   IFID_write_o          IF/ID register enable
//   load_use_o            load-use hazard detected this cycle
//   stall_cnt_o           saturating count of load-use bubbles
//   flush_cnt_o           saturating count of flush cycles

module id_ex_hazard_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_ID_i,
    input  logic [CTRL_W-1:0] ctrl_ID_i,
    input  logic [DATA_W-1:0] rs_data_ID_i,
    input  logic [DATA_W-1:0] rt_data_ID_i,
    input  logic [DATA_W-1:0] imm_ID_i,
    input  logic [DATA_W-1:0] pc4_ID_i,
    input  logic [REG_AW-1:0] RSaddr_ID_i,
    input  logic [REG_AW-1:0] RTaddr_ID_i,
    input  logic [REG_AW-1:0] RDaddr_ID_i,
    input  logic              flush_i,
    input  logic              ext_stall_i,
    output logic              valid_IDEX_o,
    output logic [CTRL_W-1:0] ctrl_IDEX_o,
    output logic [DATA_W-1:0] rs_data_IDEX_o,
    output logic [DATA_W-1:0] rt_data_IDEX_o,
    output logic [DATA_W-1:0] imm_IDEX_o,
    output logic [DATA_W-1:0] pc4_IDEX_o,
    output logic [REG_AW-1:0] RSaddr_IDEX_o,
    output logic [REG_AW-1:0] RTaddr_IDEX_o,
    output logic [REG_AW-1:0] RDaddr_IDEX_o,
    output logic              PC_write_o,
    output logic              IFID_write_o,
    output logic              load_use_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    logic              valid_q,   valid_d;
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic [DATA_W-1:0] pc4_q,     pc4_d;
    logic [REG_AW-1:0] rs_addr_q, rs_addr_d;
    logic [REG_AW-1:0] rt_addr_q, rt_addr_d;
    logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic load_use;

    // A load in EX whose destination is read by the ID instruction. Writes to
    // $zero never create a dependency.
    assign load_use = valid_q & ctrl_q[1] & (rt_addr_q != '0) & valid_ID_i
                    & ((rt_addr_q == RSaddr_ID_i) | (rt_addr_q == RTaddr_ID_i));

    // A flush discards the dependent instruction, so the front end may advance.
    assign PC_write_o   = ~ext_stall_i & (flush_i | ~load_use);
    assign IFID_write_o = ~ext_stall_i & (flush_i | ~load_use);
    assign load_use_o   = load_use;

    always_comb begin
        valid_d     = valid_q;
        ctrl_d      = ctrl_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        pc4_d       = pc4_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        rd_addr_d   = rd_addr_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (ext_stall_i) begin
            // hold everything
        end else if (flush_i || load_use) begin
            // Bubble zeroes addresses too so forwarding never matches it.
            valid_d   = 1'b0;
            ctrl_d    = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            pc4_d     = '0;
            rs_addr_d = '0;
            rt_addr_d = '0;
            rd_addr_d = '0;
            if (flush_i) begin
                if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
            end else begin
                if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end else begin
            valid_d   = valid_ID_i;
            ctrl_d    = ctrl_ID_i;
            rs_data_d = rs_data_ID_i;
            rt_data_d = rt_data_ID_i;
            imm_d     = imm_ID_i;
            pc4_d     = pc4_ID_i;
            rs_addr_d = RSaddr_ID_i;
            rt_addr_d = RTaddr_ID_i;
            rd_addr_d = RDaddr_ID_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= 1'b0;
            ctrl_q      <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            pc4_q       <= '0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rd_addr_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            pc4_q       <= pc4_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            rd_addr_q   <= rd_addr_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign valid_IDEX_o   = valid_q;
    assign ctrl_IDEX_o    = ctrl_q;
    assign rs_data_IDEX_o = rs_data_q;
    assign rt_data_IDEX_o = rt_data_q;
    assign imm_IDEX_o     = imm_q;
    assign pc4_IDEX_o     = pc4_q;
    assign RSaddr_IDEX_o  = rs_addr_q;
    assign RTaddr_IDEX_o  = rt_addr_q;
    assign RDaddr_IDEX_o  = rd_addr_q;
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;

endmodule
